// File: rtl/uart_queue_transmitter.sv
// 8N1 UART transmitter draining a CPU-written circular byte queue.
// Head pointer queue_s advances once per completed frame; LED counts frames.
module uart_queue_transmitter #(
   parameter int CLKS_PER_BIT = 868,
   parameter int QUEUE_DEPTH  = 512
) (
   input  logic                        CLK,
   input  logic                        INITIALIZE,
   input  logic [QUEUE_DEPTH-1:0][7:0] send_queue,
   input  logic [8:0]                  queue_t,
   output logic [8:0]                  queue_s,
   output logic                        UART_TX,
   output logic [7:0]                  LED,
   output logic                        busy
);

   localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic [15:0] timer;
   logic [2:0]  bit_idx;
   logic [2:0]  next_idx;
   logic [7:0]  shreg;
   logic        bit_done;

   assign bit_done = (timer == LAST_TICK);
   assign next_idx = bit_idx + 3'd1;
   assign busy     = (state != IDLE);

   // UART_TX is registered and set one edge ahead of each bit period.
   always_ff @(posedge CLK) begin
      if (INITIALIZE) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         queue_s <= '0;
         LED     <= '0;
         UART_TX <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               UART_TX <= 1'b1;
               if (queue_s != queue_t) begin
                  shreg   <= send_queue[queue_s];
                  timer   <= '0;
                  bit_idx <= '0;
                  UART_TX <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  timer   <= '0;
                  UART_TX <= shreg[0];
                  state   <= DATA;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  timer <= '0;
                  if (bit_idx == 3'd7) begin
                     UART_TX <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_idx <= next_idx;
                     UART_TX <= shreg[next_idx];
                  end
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  timer   <= '0;
                  queue_s <= queue_s + 9'd1;
                  LED     <= LED + 8'd1;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               UART_TX <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_queue_transmitter.sv
// Bench for uart_queue_transmitter: table of bytes with expected line shapes,
// scoreboard of queued bytes, plus directed back-to-back/wrap/reset sequences.
module tb_uart_queue_transmitter;

   localparam int CPB = 4;

   logic               CLK = 1'b0;
   logic               INITIALIZE;
   logic [511:0][7:0]  send_queue;
   logic [8:0]         queue_t;
   logic [8:0]         queue_s;
   logic               UART_TX;
   logic [7:0]         LED;
   logic               busy;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  sb[$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;   // line levels in send order, start bit in [9]
   } vec_t;

   vec_t vec[7];

   always #5 CLK = ~CLK;

   uart_queue_transmitter #(.CLKS_PER_BIT(CPB), .QUEUE_DEPTH(512)) dut (
      .CLK        (CLK),
      .INITIALIZE (INITIALIZE),
      .send_queue (send_queue),
      .queue_t    (queue_t),
      .queue_s    (queue_s),
      .UART_TX    (UART_TX),
      .LED        (LED),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      INITIALIZE = 1'b1;
      queue_t    = '0;
      sb.delete();
      tick(2);
      INITIALIZE = 1'b0;
   endtask

   // Wait for a start bit, then capture 10 bits, requiring each to hold CPB samples.
   task automatic get_frame(input int max_wait, output logic [9:0] line,
                            output int waited, output bit ok);
      ok     = 1'b1;
      waited = 0;
      line   = '0;
      while (UART_TX !== 1'b0 && waited < max_wait) begin
         tick(1);
         waited++;
      end
      if (UART_TX !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) tick(1);
            if (k == 0) line[9-b] = UART_TX;
            else if (UART_TX !== line[9-b]) ok = 1'b0;
         end
      end
   endtask

   task automatic expect_frame(input string name, input int exp_wait, output logic [9:0] line);
      int         waited;
      bit         ok;
      logic [7:0] got;
      logic [7:0] exp;
      get_frame(2000, line, waited, ok);
      check({name, " latency"}, 32'(waited), 32'(exp_wait));
      check({name, " bit timing"}, 32'(ok), 32'd1);
      for (int i = 0; i < 8; i++) got[i] = line[8-i];
      if (sb.size() == 0) begin
         check({name, " scoreboard empty"}, 32'(got), 32'hFFFF_FFFF);
      end else begin
         exp = sb.pop_front();
         check({name, " byte"}, 32'(got), 32'(exp));
      end
      check({name, " stop bit"}, 32'(line[0]), 32'd1);
   endtask

   initial begin
      logic [9:0] line;
      logic [8:0] q0;
      bit         good;
      int         cnt;

      vec[0] = '{8'hA5, 10'b0101001011};
      vec[1] = '{8'h00, 10'b0000000001};
      vec[2] = '{8'hFF, 10'b0111111111};
      vec[3] = '{8'h55, 10'b0101010101};
      vec[4] = '{8'h81, 10'b0100000011};
      vec[5] = '{8'h3C, 10'b0001111001};
      vec[6] = '{8'hC3, 10'b0110000111};

      send_queue = '0;
      queue_t    = '0;
      INITIALIZE = 1'b1;
      tick(1);
      do_reset();
      check("reset tx", 32'(UART_TX), 32'd1);
      check("reset queue_s", 32'(queue_s), 32'd0);
      check("reset led", 32'(LED), 32'd0);
      check("reset busy", 32'(busy), 32'd0);

      // Single-byte frames from the table, one at a time.
      for (int i = 0; i < 7; i++) begin
         send_queue[queue_t] = vec[i].data;
         sb.push_back(vec[i].data);
         queue_t = queue_t + 9'd1;
         expect_frame($sformatf("tbl%0d", i), 1, line);
         check($sformatf("tbl%0d line", i), 32'(line), 32'(vec[i].line));
         tick(1);
         check($sformatf("tbl%0d queue_s", i), 32'(queue_s), 32'(i + 1));
         check($sformatf("tbl%0d led", i), 32'(LED), 32'(i + 1));
         check($sformatf("tbl%0d busy", i), 32'(busy), 32'd0);
         check($sformatf("tbl%0d idle tx", i), 32'(UART_TX), 32'd1);
      end

      // Empty hold.
      good = 1'b1;
      q0   = queue_s;
      repeat (1000) begin
         tick(1);
         if (UART_TX !== 1'b1 || busy !== 1'b0 || queue_s !== q0) good = 1'b0;
      end
      check("empty hold", 32'(good), 32'd1);

      // Back-to-back: exactly one idle-high cycle between frames.
      do_reset();
      send_queue[0] = 8'h00;
      send_queue[1] = 8'hFF;
      send_queue[2] = 8'h55;
      sb.push_back(8'h00);
      sb.push_back(8'hFF);
      sb.push_back(8'h55);
      queue_t = 9'd3;
      expect_frame("b2b0", 1, line);
      expect_frame("b2b1", 2, line);
      expect_frame("b2b2", 2, line);
      tick(1);
      check("b2b queue_s", 32'(queue_s), 32'd3);
      check("b2b led", 32'(LED), 32'd3);

      // In-flight immunity: slot overwritten during DATA.
      send_queue[3] = 8'h81;
      sb.push_back(8'h81);
      queue_t = 9'd4;
      fork
         expect_frame("immune", 1, line);
         begin
            tick(12);
            send_queue[3] = 8'h00;
         end
      join
      tick(1);
      check("immune queue_s", 32'(queue_s), 32'd4);

      // Wrap: drain 511 bytes, then send slot 511 and see queue_s roll to 0.
      do_reset();
      for (int i = 0; i < 511; i++) send_queue[i] = 8'(i);
      queue_t = 9'd511;
      cnt = 0;
      while (queue_s !== 9'd511 && cnt < 511 * 41 + 100) begin
         tick(1);
         cnt++;
      end
      check("drain queue_s", 32'(queue_s), 32'd511);
      check("drain led", 32'(LED), 32'd255);
      send_queue[511] = 8'h3C;
      sb.push_back(8'h3C);
      queue_t = 9'd0;
      expect_frame("wrap", 1, line);
      tick(1);
      check("wrap queue_s", 32'(queue_s), 32'd0);
      check("wrap led", 32'(LED), 32'd0);

      // Mid-frame reset at cycle 17 of a C3 frame.
      send_queue[0] = 8'hC3;
      queue_t = 9'd1;
      tick(1);
      check("mid start bit", 32'(UART_TX), 32'd0);
      tick(15);
      check("mid bit2", 32'(UART_TX), 32'd0);
      INITIALIZE = 1'b1;
      queue_t    = 9'd0;
      tick(1);
      check("mid rst tx", 32'(UART_TX), 32'd1);
      check("mid rst queue_s", 32'(queue_s), 32'd0);
      check("mid rst led", 32'(LED), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      INITIALIZE = 1'b0;
      good = 1'b1;
      repeat (100) begin
         tick(1);
         if (UART_TX !== 1'b1 || busy !== 1'b0 || queue_s !== 9'd0) good = 1'b0;
      end
      check("mid rst quiet", 32'(good), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_queue_transmitter.md
UART_QUEUE_TRANSMITTER -- requirements
Module: uart_queue_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the clock cycles per UART bit (115200 baud at 100 MHz); legal range is 2 to 65535.
REQ-002 Parameter QUEUE_DEPTH, default 512, SHALL set the send_queue entry count; it is fixed at 512 for 9-bit pointers.
REQ-003 CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 INITIALIZE, input, 1 bit: reset, synchronous and active-high.
REQ-005 send_queue, input, 512 x 8 bits: circular byte queue written by the CPU.
REQ-006 queue_t, input, 9 bits: producer tail, the next slot the CPU will write.
REQ-007 queue_s, output, 9 bits: consumer head, the next slot this block will send.
REQ-008 UART_TX, output, 1 bit: serial line, 8N1, idle high.
REQ-009 LED, output, 8 bits: low 8 bits of the count of frames completed since reset.
REQ-010 busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement a four-state FSM: IDLE, START, DATA, STOP.
REQ-012 The queue SHALL be empty when queue_s == queue_t; the block SHALL never read a slot while the queue is empty.
REQ-013 IDLE with queue non-empty:
  - latch send_queue[queue_s] into the shift register;
  - clear the bit timer and bit index;
  - go to START on the next edge.
REQ-014 START SHALL drive UART_TX=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA SHALL drive the 8 latched bits LSB first, each for exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-016 STOP SHALL drive UART_TX=1 for exactly CLKS_PER_BIT cycles.
REQ-017 On the last STOP cycle the block SHALL, at the same edge:
  - set queue_s <= queue_s+1 mod 512;
  - increment the frame counter;
  - return to IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-019 Back-to-back frames SHALL be separated by exactly one IDLE cycle with UART_TX=1.
REQ-020 Latency from queue_t becoming non-equal (sampled in IDLE) to the UART_TX falling edge SHALL be 1 cycle.
REQ-021 Writes to send_queue or changes to queue_t during a frame SHALL NOT affect the byte in flight; the new byte is evaluated only in IDLE.
REQ-022 queue_s SHALL wrap from 511 to 0.
REQ-023 A full queue (queue_t+1 == queue_s) SHALL be drained normally; full-avoidance is the producer's responsibility.
REQ-024 UART_TX SHALL come from a register; it has no combinational path from any input.
REQ-025 The bit timer SHALL be at least 16 bits wide and count 0 to CLKS_PER_BIT-1.
REQ-026 The frame counter SHALL be 8 bits, wrap 255 to 0, and drive LED directly.

Reset
REQ-027 When INITIALIZE=1 at an edge, the following SHALL hold on the next cycle:
  - state IDLE;
  - UART_TX=1, queue_s=0, LED=0, busy=0;
  - timer, bit index and shift register cleared.
REQ-028 Reset mid-frame SHALL abandon the frame (no partial retry), with UART_TX high the next cycle.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, all with CLKS_PER_BIT=4:
  - Single byte: send_queue[0]=8'hA5, queue_t 0->1. Required: UART_TX low 1 cycle later; line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; queue_s=1 and LED=1 after 40 cycles; busy low.
  - Back-to-back: slots 0..2 = 8'h00, 8'hFF, 8'h55, queue_t=3. Required: three 40-cycle frames each separated by 1 idle-high cycle; queue_s=3, LED=3.
  - Wrap: reset, then drain 511 bytes; set send_queue[511]=8'h3C and queue_t=0 (queue_s=511). Required: 8'h3C is sent and queue_s becomes 0.
  - Mid-frame reset: assert INITIALIZE at cycle 17 of a frame for 8'hC3. Required: UART_TX=1, queue_s=0, LED=0 the next cycle; no further toggling while queue_t=0.
  - In-flight immunity: overwrite send_queue[queue_s] with 8'h00 during DATA of an 8'h81 frame. Required: the line still carries 8'h81.
  - Empty hold: queue_t==queue_s for 1000 cycles. Required: UART_TX constant 1, busy=0, queue_s unchanged.
